// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the hazard/stall controller.
// Holds Tuse/Tnew encodings, the $0 register index and default mult/div latencies.
package pipe_pkg;

  // Tuse value meaning "operand not read by this instruction"
  localparam logic [1:0] TUSE_NONE = 2'd3;
  // Tnew value meaning "result already forwardable"
  localparam logic [1:0] TNEW_ZERO = 2'd0;
  // Architectural zero register; writes to it are discarded
  localparam logic [4:0] REG_ZERO  = 5'd0;

  // Default mult/div occupancy after a start, in cycles
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Width of the mult/div busy counter
  localparam int unsigned MD_CNT_W = 4;

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker: loads a latency on a start and counts down to
// zero. A start that arrives while the unit is still busy is ignored.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_start,
  input  logic e_md_is_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] r_count;
  logic                w_busy;

  assign w_busy  = (r_count != '0);
  assign md_busy = w_busy;

  // Load on a legal start, otherwise decrement toward zero and stay there
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (e_md_start && !w_busy) begin
      r_count <= e_md_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (w_busy) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
// Compares D-stage Tuse against E/M Tnew for rs and rt, and stalls mult/div
// instructions in D while the mult/div unit is occupied.
// Optional feature macro: STALL_CNT_EN adds a 32-bit stall_cycles counter output.
module stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [1:0]  id_tuse_rs,
  input  logic [1:0]  id_tuse_rt,
  input  logic        id_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        ifu_enable,
  output logic        fd_enable,
  output logic        de_flush,
  output logic        stall,
`ifdef STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        md_busy
);

  logic [4:0] w_src_addr [2];
  logic [1:0] w_src_tuse [2];
  logic [1:0] w_src_stall;
  logic       w_stall_md;
  logic       w_stall_any;
  logic       w_md_busy;

  assign w_src_addr[0] = id_rs_addr;
  assign w_src_tuse[0] = id_tuse_rs;
  assign w_src_addr[1] = id_rt_addr;
  assign w_src_tuse[1] = id_tuse_rt;

  // Same RAW check for each source operand (0 = rs, 1 = rt). A source that is
  // never read, or a producer whose result is already forwardable, cannot stall.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic w_hit_e;
    logic w_hit_m;

    assign w_hit_e = (e_wa == w_src_addr[gi]) && (e_tnew != TNEW_ZERO)
                   && (w_src_tuse[gi] < e_tnew);
    assign w_hit_m = (m_wa == w_src_addr[gi]) && (m_tnew != TNEW_ZERO)
                   && (w_src_tuse[gi] < m_tnew);

    assign w_src_stall[gi] = (w_src_addr[gi] != REG_ZERO)
                           && (w_src_tuse[gi] != TUSE_NONE)
                           && (w_hit_e || w_hit_m);
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk         (clk),
    .reset       (reset),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .md_busy     (w_md_busy)
  );

  // A mult/div op in D waits through the issuing cycle and the whole busy window
  assign w_stall_md  = id_is_md && (w_md_busy || e_md_start);

  // Reset forces the pipeline to run so no stale hazard survives it
  assign w_stall_any = !reset && (w_src_stall[0] || w_src_stall[1] || w_stall_md);

  assign stall      = w_stall_any;
  assign de_flush   = w_stall_any;
  assign ifu_enable = !w_stall_any;
  assign fd_enable  = !w_stall_any;
  assign md_busy    = w_md_busy;

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Free-running count of stalled cycles; wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall_any) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and stall controller for the five-stage MIPS pipeline. It drives the fetch unit's `enable` and the F/D register enable, and it flushes the D/E register whenever the instruction in D cannot proceed. Stalls come from two sources: register read-after-write hazards resolved by comparing Tuse against Tnew, and occupancy of the multi-cycle mult/div unit, which this block tracks with an internal busy counter.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy cycles after a mult/multu start
- `DIV_CYCLES`, 10, busy cycles after a div/divu start

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `id_rs_addr`  in  5  rs field of the instruction in D
- `id_rt_addr`  in  5  rt field of the instruction in D
- `id_tuse_rs`  in  2  cycles until D needs rs; 3 means unused
- `id_tuse_rt`  in  2  cycles until D needs rt; 3 means unused
- `id_is_md`  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo
- `e_wa`  in  5  destination register of the instruction in E
- `e_tnew`  in  2  cycles until E's result is forwardable
- `m_wa`  in  5  destination register of the instruction in M
- `m_tnew`  in  2  cycles until M's result is forwardable
- `e_md_start`  in  1  mult/div issuing in E this cycle
- `e_md_is_div`  in  1  qualifies `e_md_start`: 1 = div/divu
- `ifu_enable`  out  1  PC update enable to the fetch unit
- `fd_enable`  out  1  F/D pipeline register enable
- `de_flush`  out  1  insert a bubble into D/E
- `stall`  out  1  combined stall indication
- `md_busy`  out  1  mult/div unit occupied

## Operation
- `stall_rs` = (`id_rs_addr` != 0) && ((`e_wa` == `id_rs_addr` && `id_tuse_rs` < `e_tnew`) || (`m_wa` == `id_rs_addr` && `id_tuse_rs` < `m_tnew`)).
- `stall_rt` is the same expression using the rt inputs.
- `stall_md` = `id_is_md` && (`md_busy` || `e_md_start`).
- `stall` = `stall_rs` | `stall_rt` | `stall_md`.
- `ifu_enable` = `fd_enable` = !`stall`; `de_flush` = `stall`. All four are combinational from the inputs and the counter state.
- The busy counter is 4 bits wide, unsigned, and saturates at 0.
  - If `e_md_start` && !`md_busy`: load `DIV_CYCLES` when `e_md_is_div`, else `MULT_CYCLES`.
  - Else if count != 0: decrement by 1.
  - `md_busy` = (count != 0), taken from the register.
- Counter states:
  - IDLE (count = 0).
  - BUSY (count ≥ 1), which returns to IDLE after exactly N decrements.
- Writes to $0 never cause a stall.

## Timing
- Reset: count = 0 and `md_busy` = 0. While `reset` is high, `stall` = `de_flush` = 0 and `ifu_enable` = `fd_enable` = 1.
- Counter timing: a start sampled at edge k makes `md_busy` high from cycle k+1 through k+N inclusive, and low at k+N+1.
- Back-to-back mult/div: the second md instruction in D stalls during the first one's E cycle (`e_md_start`) and for all of its busy cycles. It is released on the first cycle with `md_busy` = 0.
- `e_md_start` while `md_busy` = 1 is illegal. It is ignored: no reload, and the decrement continues.
- Reset asserted mid-busy: count = 0 at the next edge. There is no residual stall.
- All stall outputs settle in the same cycle as their inputs. There is zero latency from a hazard to `ifu_enable` going low.

## Configuration
- `STALL_CNT_EN`, when defined:
  - Adds output `stall_cycles` (32 bits): a free-running count of cycles with `stall` = 1.
  - The count is cleared by `reset` and wraps from 0xFFFF_FFFF to 0.
- When undefined: the port and its register are absent, and behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg` holds:
  - Tuse/Tnew constants: `TUSE_NONE` = 3, `TNEW_ZERO` = 0.
  - Register-0 constant `REG_ZERO`.
  - Default mult/div latencies, which are the parameter defaults.
- One sub-module, `md_busy_counter`. It contains the load/decrement counter and drives `md_busy`. The top level holds only the hazard compare logic.

## Test plan
- D rs = 8 with `id_tuse_rs` = 0; E `e_wa` = 8 with `e_tnew` = 1 → `stall` = 1, `ifu_enable` = 0, `de_flush` = 1. With `e_wa` = 9 instead → `stall` = 0.
- `id_rt_addr` = 0 and `e_wa` = 0 with `e_tnew` = 2 and `id_tuse_rt` = 0 → `stall` = 0.
- `e_md_start` = 1 with `e_md_is_div` = 0 at edge 0 → `md_busy` is high in cycles 1–5 and low in cycle 6. With `e_md_is_div` = 1 → high in cycles 1–10.
- Mult in E (`e_md_start`) with an mflo in D (`id_is_md`) → stall for 6 cycles total, then `ifu_enable` = 1.
- `reset` pulsed while count = 7 → `md_busy` = 0 on the next cycle, and outputs are forced non-stalling during reset.
- With `STALL_CNT_EN` defined: hold `stall` high for 4 cycles → `stall_cycles` = 4. Preload near the wrap point → rolls over to 0.
